// File: rtl/array_pkg.sv
// Shared definitions for the bit-serial array sequencer: opcodes, instruction
// field positions, FSM state encoding and opcode classification helpers.
package array_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FIELD_W = 5;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RD_LSB  = 21;
  localparam int unsigned RS1_LSB = 16;
  localparam int unsigned RS2_LSB = 11;

  localparam logic [OPC_W-1:0] OP_ADD = 6'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 6'd1;
  localparam logic [OPC_W-1:0] OP_AND = 6'd4;
  localparam logic [OPC_W-1:0] OP_E   = 6'd5;
  localparam logic [OPC_W-1:0] OP_W   = 6'd6;
  localparam logic [OPC_W-1:0] OP_S   = 6'd7;
  localparam logic [OPC_W-1:0] OP_N   = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  function automatic logic is_alu_op(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic is_shift_op(input logic [OPC_W-1:0] op);
    return (op == OP_E) || (op == OP_W) || (op == OP_S) || (op == OP_N);
  endfunction

  // One-hot {north,south,west,east}; zero for non-shift opcodes.
  function automatic logic [3:0] dir_of(input logic [OPC_W-1:0] op);
    case (op)
      OP_E:    return 4'b0001;
      OP_W:    return 4'b0010;
      OP_S:    return 4'b0100;
      OP_N:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/array_sequencer_if.sv
// Instruction handshake plus PE-array / bit-plane RAM control bundle.
interface array_sequencer_if
  import array_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic               start;
  logic [INSTR_W-1:0] instruction;
  logic               busy;
  logic               done;
  logic               err;
  logic [3:0]         alu_op;
  logic               alu_clr;
  logic [3:0]         dir;
  logic [ADDR_W-1:0]  addra;
  logic [ADDR_W-1:0]  addrb;
  logic               wea;
  logic               web;

  modport master (
    output start, instruction,
    input  busy, done, err, alu_op, alu_clr, dir, addra, addrb, wea, web
  );

  modport slave (
    input  start, instruction,
    output busy, done, err, alu_op, alu_clr, dir, addra, addrb, wea, web
  );

endinterface

// File: rtl/seq_addr_gen.sv
// Register base addresses (field*LENGTH, truncated to ADDR_W) and instruction
// legality check for the sequencer.
module seq_addr_gen
  import array_pkg::*;
#(
  parameter int unsigned LENGTH   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FIELD_W-1:0] rd,
  input  logic [FIELD_W-1:0] rs1,
  input  logic [FIELD_W-1:0] rs2,
  output logic [ADDR_W-1:0]  rd_base_c,
  output logic [ADDR_W-1:0]  rs1_base_c,
  output logic [ADDR_W-1:0]  rs2_base_c,
  output logic               legal_c
);

  localparam int unsigned BASE_W = ADDR_W + 1;
  localparam int unsigned CMP_W  = FIELD_W + 1;

  function automatic logic [ADDR_W-1:0] base_of(input logic [FIELD_W-1:0] f);
    logic [BASE_W-1:0] prod;
    prod = BASE_W'(f) * BASE_W'(LENGTH);
    return prod[ADDR_W-1:0];
  endfunction

  function automatic logic in_range(input logic [FIELD_W-1:0] f);
    return {1'b0, f} < CMP_W'(NUM_REGS);
  endfunction

  assign rd_base_c  = base_of(rd);
  assign rs1_base_c = base_of(rs1);
  assign rs2_base_c = base_of(rs2);

  // Shift ops never read rs2, so its value is not allowed to reject them.
  assign legal_c = (is_alu_op(opcode) && in_range(rd) && in_range(rs1) && in_range(rs2)) ||
                   (is_shift_op(opcode) && in_range(rd) && in_range(rs1));

endmodule

// File: rtl/array_sequencer.sv
// Bit-serial instruction sequencer: steps RD/WR cycles over every row of a
// register, driving bit-plane RAM ports, PE opcode and neighbour strobes.
module array_sequencer
  import array_pkg::*;
#(
  parameter int unsigned LENGTH   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  array_sequencer_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(LENGTH);
  localparam logic [IDX_W-1:0] IDX_LAST_ALU = IDX_W'(LENGTH - 1);
  localparam logic [IDX_W-1:0] IDX_LAST_SH  = IDX_W'(LENGTH - 2);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [3:0]         alu_op_q, alu_op_d;
  logic               alu_clr_q, alu_clr_d;
  logic [3:0]         dir_q, dir_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [ADDR_W-1:0]  addrb_q, addrb_d;
  logic               wea_q, wea_d;
  logic               web_q, web_d;

  logic [INSTR_W-1:0] cur_instr_c;
  logic [OPC_W-1:0]   opc_c;
  logic [ADDR_W-1:0]  rd_base_c, rs1_base_c, rs2_base_c;
  logic               legal_c, shift_c, last_c;
  logic               accept_c, reject_c, finish_c;
  logic               unused_instr_c;

  // While idle, decode the incoming word; once busy, only the latched copy.
  assign cur_instr_c    = (state_q == ST_IDLE) ? bus.instruction : instr_q;
  assign opc_c          = cur_instr_c[OPC_LSB +: OPC_W];
  assign shift_c        = is_shift_op(opc_c);
  assign last_c         = shift_c ? (idx_q == IDX_LAST_SH) : (idx_q == IDX_LAST_ALU);
  assign unused_instr_c = ^cur_instr_c[RS2_LSB-1:0];

  seq_addr_gen #(
    .LENGTH   (LENGTH),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .opcode     (opc_c),
    .rd         (cur_instr_c[RD_LSB  +: FIELD_W]),
    .rs1        (cur_instr_c[RS1_LSB +: FIELD_W]),
    .rs2        (cur_instr_c[RS2_LSB +: FIELD_W]),
    .rd_base_c  (rd_base_c),
    .rs1_base_c (rs1_base_c),
    .rs2_base_c (rs2_base_c),
    .legal_c    (legal_c)
  );

  // State, index and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      instr_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      alu_op_q  <= '0;
      alu_clr_q <= 1'b0;
      dir_q     <= '0;
      addra_q   <= '0;
      addrb_q   <= '0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      alu_op_q  <= alu_op_d;
      alu_clr_q <= alu_clr_d;
      dir_q     <= dir_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      wea_q     <= wea_d;
      web_q     <= web_d;
    end
  end

  // Next state, bit index and instruction latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    instr_d  = instr_q;
    accept_c = 1'b0;
    reject_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (legal_c) begin
            accept_c = 1'b1;
            instr_d  = bus.instruction;
            state_d  = ST_RD;
            idx_d    = '0;
          end else begin
            reject_c = 1'b1;
          end
        end
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        if (last_c) begin
          finish_c = 1'b1;
          state_d  = ST_IDLE;
          idx_d    = '0;
        end else begin
          state_d = ST_RD;
          idx_d   = idx_q + (shift_c ? IDX_W'(2) : IDX_W'(1));
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed for the upcoming state so they register in step with it.
  always_comb begin
    busy_d    = 1'b0;
    done_d    = finish_c | reject_c;
    err_d     = err_q;
    alu_op_d  = alu_op_q;
    alu_clr_d = 1'b0;
    dir_d     = '0;
    addra_d   = '0;
    addrb_d   = '0;
    wea_d     = 1'b0;
    web_d     = 1'b0;
    if (accept_c) err_d = 1'b0;
    if (reject_c) err_d = 1'b1;
    case (state_d)
      ST_RD: begin
        busy_d    = 1'b1;
        alu_op_d  = opc_c[3:0];
        alu_clr_d = accept_c;
        dir_d     = dir_of(opc_c);
        addra_d   = rs1_base_c + ADDR_W'(idx_d);
        addrb_d   = shift_c ? (rs1_base_c + ADDR_W'(idx_d) + ADDR_W'(1))
                            : (rs2_base_c + ADDR_W'(idx_d));
      end
      ST_WR: begin
        busy_d   = 1'b1;
        alu_op_d = opc_c[3:0];
        dir_d    = dir_of(opc_c);
        addra_d  = rd_base_c + ADDR_W'(idx_d);
        addrb_d  = shift_c ? (rd_base_c + ADDR_W'(idx_d) + ADDR_W'(1)) : addrb_q;
        wea_d    = 1'b1;
        web_d    = shift_c;
      end
      default: ;
    endcase
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.alu_op  = alu_op_q;
  assign bus.alu_clr = alu_clr_q;
  assign bus.dir     = dir_q;
  assign bus.addra   = addra_q;
  assign bus.addrb   = addrb_q;
  assign bus.wea     = wea_q;
  assign bus.web     = web_q;

endmodule

// File: tb/tb_array_sequencer.sv
// Directed scoreboard bench for array_sequencer (32 regs) plus a 16-register
// build used for register-range rejection.
module tb_array_sequencer;
  import array_pkg::*;

  localparam int unsigned L = 32;
  localparam int unsigned A = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  array_sequencer_if #(.ADDR_W(A)) bus   ();
  array_sequencer_if #(.ADDR_W(A)) bus16 ();

  array_sequencer #(.LENGTH(L), .NUM_REGS(32), .ADDR_W(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  array_sequencer #(.LENGTH(L), .NUM_REGS(16), .ADDR_W(A)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  typedef struct packed {
    logic         busy;
    logic         done;
    logic         err;
    logic         alu_clr;
    logic [3:0]   alu_op;
    logic [3:0]   dir;
    logic [A-1:0] addra;
    logic [A-1:0] addrb;
    logic         wea;
    logic         web;
  } obs_t;

  obs_t       q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cnt_wea = 0;
  int         cnt_clr = 0;
  logic       m_err   = 1'b0;
  logic [3:0] m_alu_op = 4'd0;
  string      tag = "init";

  task automatic check(input string t, input logic [63:0] o, input logic [63:0] e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, o, e);
    end
  endtask

  // Reference model: push the per-cycle expected outputs of one start request.
  task automatic push_seq(input logic [31:0] ins, input int n);
    logic [5:0] op;
    int rd, rs1, rs2;
    logic alu, sh, legal;
    logic [3:0] d;
    obs_t e;
    op  = ins[31:26];
    rd  = int'(ins[25:21]);
    rs1 = int'(ins[20:16]);
    rs2 = int'(ins[15:11]);
    alu = (op == 6'd0) || (op == 6'd1) || (op == 6'd4);
    sh  = (op >= 6'd5) && (op <= 6'd8);
    legal = (alu && rd < n && rs1 < n && rs2 < n) || (sh && rd < n && rs1 < n);
    if (!legal) begin
      m_err = 1'b1;
      e = '0; e.done = 1'b1; e.err = 1'b1; e.alu_op = m_alu_op;
      q.push_back(e);
      return;
    end
    m_err    = 1'b0;
    m_alu_op = op[3:0];
    d = (op == 6'd5) ? 4'b0001 : (op == 6'd6) ? 4'b0010 :
        (op == 6'd7) ? 4'b0100 : (op == 6'd8) ? 4'b1000 : 4'b0000;
    for (int i = 0; i < int'(L); i += (sh ? 2 : 1)) begin
      e = '0; e.busy = 1'b1; e.alu_op = m_alu_op; e.dir = d; e.alu_clr = (i == 0);
      e.addra = A'(rs1 * int'(L) + i);
      e.addrb = sh ? A'(rs1 * int'(L) + i + 1) : A'(rs2 * int'(L) + i);
      q.push_back(e);
      e.alu_clr = 1'b0;
      e.addra = A'(rd * int'(L) + i);
      if (sh) e.addrb = A'(rd * int'(L) + i + 1);
      e.wea = 1'b1; e.web = sh;
      q.push_back(e);
    end
    e = '0; e.done = 1'b1; e.alu_op = m_alu_op;
    q.push_back(e);
  endtask

  // Advance one clock and compare the main DUT against the scoreboard head.
  task automatic tick();
    obs_t o, e;
    @(posedge clk);
    #1;
    o.busy = bus.busy;   o.done = bus.done;   o.err = bus.err;
    o.alu_clr = bus.alu_clr; o.alu_op = bus.alu_op; o.dir = bus.dir;
    o.addra = bus.addra; o.addrb = bus.addrb; o.wea = bus.wea; o.web = bus.web;
    if (q.size() > 0) e = q.pop_front();
    else begin
      e = '0; e.err = m_err; e.alu_op = m_alu_op;
    end
    if (o.wea === 1'b1) cnt_wea++;
    if (o.alu_clr === 1'b1) cnt_clr++;
    check(tag, 64'(o), 64'(e));
  endtask

  task automatic drain();
    while (q.size() > 0) tick();
  endtask

  task automatic run_one(input string t, input logic [31:0] ins);
    tag = t;
    bus.instruction = ins;
    bus.start = 1'b1;
    push_seq(ins, 32);
    tick();
    bus.start = 1'b0;
    drain();
  endtask

  initial begin
    int j;
    reset = 1'b0;
    bus.start = 1'b0;   bus.instruction = '0;
    bus16.start = 1'b0; bus16.instruction = '0;

    tag = "reset";
    tick(); tick();
    check("reset16", 64'({bus16.busy, bus16.done, bus16.err, bus16.wea, bus16.web, bus16.alu_op}), 64'd0);
    reset = 1'b1;
    tag = "idle";
    tick();

    cnt_wea = 0; cnt_clr = 0;
    run_one("add", 32'h00400800);
    check("add_wea_count", 64'(cnt_wea), 64'd32);
    check("add_clr_count", 64'(cnt_clr), 64'd1);
    tag = "idle_after_add"; tick();

    cnt_wea = 0;
    run_one("east", 32'h14610000);
    check("east_wea_count", 64'(cnt_wea), 64'd16);

    tag = "illegal";
    bus.instruction = 32'h0C000000;
    bus.start = 1'b1;
    push_seq(32'h0C000000, 32);
    tick();
    bus.start = 1'b0;
    tick(); tick();
    run_one("and_clears_err", 32'h10000000);

    tag = "regs16";
    bus16.instruction = 32'h02800000;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check("regs16_reject", 64'({bus16.busy, bus16.done, bus16.err, bus16.wea, bus16.web, bus16.alu_clr}), 64'(6'b011000));
    tick();
    check("regs16_err_sticky", 64'({bus16.busy, bus16.done, bus16.err}), 64'(3'b001));
    bus16.instruction = 32'h2022A000;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    check("regs16_shift_rs2_ignored",
          64'({bus16.busy, bus16.err, bus16.alu_clr, bus16.dir, bus16.addra, bus16.addrb}),
          64'({1'b1, 1'b0, 1'b1, 4'b1000, 10'd64, 10'd65}));
    repeat (40) tick();
    check("regs16_back_idle", 64'({bus16.busy, bus16.err, bus16.wea}), 64'd0);

    // start held high through SUB with junk words, then west accepted in its done cycle.
    tag = "b2b_sub";
    bus.instruction = 32'h04A63800;
    bus.start = 1'b1;
    push_seq(32'h04A63800, 32);
    tick();
    j = 0;
    while (q.size() > 0) begin
      bus.instruction = (j % 2 == 1) ? 32'h0C000000 : 32'h00400800;
      j++;
      tick();
    end
    tag = "b2b_west";
    bus.instruction = 32'h1BFE0000;
    push_seq(32'h1BFE0000, 32);
    tick();
    bus.start = 1'b0;
    drain();

    run_one("north_top_reg", 32'h201FF800);

    tag = "reset_mid";
    bus.instruction = 32'h00400800;
    bus.start = 1'b1;
    push_seq(32'h00400800, 32);
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b0;
    q.delete();
    m_err = 1'b0; m_alu_op = 4'd0;
    tick(); tick();
    reset = 1'b1;
    tick();

    cnt_wea = 0; cnt_clr = 0;
    run_one("add_after_reset", 32'h00400800);
    check("add2_wea_count", 64'(cnt_wea), 64'd32);
    check("add2_clr_count", 64'(cnt_clr), 64'd1);
    tag = "final_idle"; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
